// File: rtl/gpio_xfer_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gpio_cfg_pkg
// Purpose  : Shared definitions for the GPIO pad-configuration scheduler:
//            pad geometry, scheduler state encoding and io_ctrl reset
//            defaults.
// Revision : 1.0 - initial release
// ============================================================================
package gpio_cfg_pkg;

  localparam int NUM_PADS  = 38;
  localparam int CTRL_BITS = 13;
  localparam int PAD_W     = 6;

  // First illegal pad index, already at pad-index width for cheap compares.
  localparam logic [PAD_W-1:0] c_PAD_LIMIT = PAD_W'(NUM_PADS);

  // io_ctrl reset defaults: pads 0-1 belong to the management core.
  localparam logic [CTRL_BITS-1:0] c_CTRL_INIT_MGMT = 13'h1803;
  localparam logic [CTRL_BITS-1:0] c_CTRL_INIT_USER = 13'h0403;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOLD      = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_RUN       = 3'd4
  } sched_state_t;

  function automatic logic [CTRL_BITS-1:0] pad_reset_default(input logic [PAD_W-1:0] pad);
    return (pad < PAD_W'(2)) ? c_CTRL_INIT_MGMT : c_CTRL_INIT_USER;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_xfer_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_xfer_sched_if
// Purpose  : Write-request bundle for the two pad-configuration requesters.
//            Port A = management SoC wishbone path, port B = housekeeping SPI.
// Ports    : a_valid/a_pad/a_data/a_ready, b_valid/b_pad/b_data/b_ready
//            master = requester side, slave = scheduler side.
// Revision : 1.0 - initial release
// ============================================================================
interface gpio_xfer_sched_if import gpio_cfg_pkg::*; ();

  logic                 a_valid;
  logic [PAD_W-1:0]     a_pad;
  logic [CTRL_BITS-1:0] a_data;
  logic                 a_ready;
  logic                 b_valid;
  logic [PAD_W-1:0]     b_pad;
  logic [CTRL_BITS-1:0] b_data;
  logic                 b_ready;

  modport master (
    output a_valid, a_pad, a_data, b_valid, b_pad, b_data,
    input  a_ready, b_ready
  );

  modport slave (
    input  a_valid, a_pad, a_data, b_valid, b_pad, b_data,
    output a_ready, b_ready
  );

endinterface
`default_nettype wire

// File: rtl/gpio_xfer_sched_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : gpio_rr_arb2
// Purpose  : Two-input round-robin arbiter. When both requests are present
//            the requester not granted last time wins. The pointer moves only
//            when a grant is actually taken (accept=1).
// Ports    : clk, resetn, req_a, req_b, accept -> gnt_a, gnt_b
// Revision : 1.0 - initial release
// ============================================================================
module gpio_rr_arb2 (
  input  wire  clk,
  input  wire  resetn,
  input  wire  req_a,
  input  wire  req_b,
  input  wire  accept,
  output logic gnt_a,
  output logic gnt_b
);

  // 0 = A has priority on a tie, 1 = B has priority.
  logic r_prio_b;

  assign gnt_a = req_a & (~req_b | ~r_prio_b);
  assign gnt_b = req_b & (~req_a |  r_prio_b);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prio_b <= 1'b0;
    end else if (accept & gnt_a) begin
      r_prio_b <= 1'b1;
    end else if (accept & gnt_b) begin
      r_prio_b <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gpio_xfer_sched.sv
`default_nettype none
// ============================================================================
// Module   : gpio_xfer_sched
// Purpose  : Accepts per-pad control-word writes from two requesters into the
//            io_ctrl register file, coalesces bursts behind a hold-off timer
//            and then pulses xfer_start to the serial loader. Writes are
//            locked out while a shift is in flight.
// Ports    : clk, resetn (async, active-low), req (request bundle, slave),
//            force_xfer, auto_en, xfer_busy,
//            wr_en/wr_pad/wr_data (io_ctrl write, 1-cycle latency),
//            xfer_start, pending, sched_busy, err_pad,
//            wdog_err (only with GPIO_XFER_WDOG_EN).
// Config   : `define GPIO_XFER_WDOG_EN adds the WAIT_BUSY/RUN watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_xfer_sched
  import gpio_cfg_pkg::*;
#(
  parameter int HOLDOFF = 16
) (
  input  wire                  clk,
  input  wire                  resetn,
  gpio_xfer_sched_if.slave     req,
  input  wire                  force_xfer,
  input  wire                  auto_en,
  output logic                 wr_en,
  output logic [PAD_W-1:0]     wr_pad,
  output logic [CTRL_BITS-1:0] wr_data,
  output logic                 xfer_start,
  input  wire                  xfer_busy,
  output logic                 pending,
  output logic                 sched_busy,
`ifdef GPIO_XFER_WDOG_EN
  output logic                 wdog_err,
`endif
  output logic                 err_pad
);

  localparam logic [7:0] c_HOLD_LOAD = 8'(HOLDOFF - 1);

  sched_state_t         r_state;
  sched_state_t         w_state_nxt;
  logic                 w_gnt_a;
  logic                 w_gnt_b;
  logic                 w_accept_ok;
  logic                 w_hs;
  logic                 w_wr_ok;
  logic                 w_abort;
  logic [PAD_W-1:0]     w_pad;
  logic [CTRL_BITS-1:0] w_data;
  logic [7:0]           r_timer;
  logic                 r_pending;
  logic                 r_err_pad;
  logic                 r_wr_en;
  logic [PAD_W-1:0]     r_wr_pad;
  logic [CTRL_BITS-1:0] r_wr_data;

  gpio_rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .req_a  (req.a_valid),
    .req_b  (req.b_valid),
    .accept (w_accept_ok),
    .gnt_a  (w_gnt_a),
    .gnt_b  (w_gnt_b)
  );

  assign req.a_ready = w_gnt_a & w_accept_ok;
  assign req.b_ready = w_gnt_b & w_accept_ok;
  assign w_hs        = req.a_ready | req.b_ready;
  assign w_pad       = req.a_ready ? req.a_pad  : req.b_pad;
  assign w_data      = req.a_ready ? req.a_data : req.b_data;
  // Out-of-range writes still handshake so the requester is never stuck.
  assign w_wr_ok     = w_hs & (w_pad < c_PAD_LIMIT);

  // ---------------------------------------------------------------- FSM: state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ----------------------------------------------------------- FSM: next state
  // A write landing together with force_xfer still goes out: its io_ctrl
  // update is clocked on the same edge the loader first samples xfer_start.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (force_xfer)   w_state_nxt = ST_START;
        else if (w_wr_ok) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (force_xfer) w_state_nxt = ST_START;
        else if (!w_wr_ok && (r_timer == 8'd0) && auto_en) w_state_nxt = ST_START;
      end
      ST_START: w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (w_abort)        w_state_nxt = ST_IDLE;
        else if (xfer_busy) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_abort)         w_state_nxt = ST_IDLE;
        else if (!xfer_busy) w_state_nxt = r_pending ? ST_HOLD : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------- FSM: output
  always_comb begin
    w_accept_ok = 1'b0;
    xfer_start  = 1'b0;
    sched_busy  = 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_accept_ok = 1'b1;
        sched_busy  = 1'b0;
      end
      ST_HOLD:  w_accept_ok = 1'b1;
      ST_START: xfer_start  = 1'b1;
      default: ;
    endcase
  end

  // Hold-off timer: reloads on every accepted write or on entry to HOLD and
  // parks at zero while auto_en is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_timer <= 8'd0;
    end else if (w_wr_ok || ((w_state_nxt == ST_HOLD) && (r_state != ST_HOLD))) begin
      r_timer <= c_HOLD_LOAD;
    end else if ((r_state == ST_HOLD) && (r_timer != 8'd0)) begin
      r_timer <= r_timer - 8'd1;
    end
  end

  // pending is already low during the START cycle: every write accepted so
  // far, including one in the launching cycle, is covered by this shift.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= 1'b0;
      r_err_pad <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_pad  <= '0;
      r_wr_data <= '0;
    end else begin
      if (w_state_nxt == ST_START)  r_pending <= 1'b0;
      else if (w_wr_ok || w_abort)  r_pending <= 1'b1;
      if (w_hs && !w_wr_ok)         r_err_pad <= 1'b1;
      r_wr_en <= w_wr_ok;
      if (w_wr_ok) begin
        r_wr_pad  <= w_pad;
        r_wr_data <= w_data;
      end
    end
  end

`ifdef GPIO_XFER_WDOG_EN
  logic [7:0] r_wdog;
  logic       r_wdog_err;

  // Counter restarts on every state change, so it measures time in the
  // current WAIT_BUSY or RUN visit only.
  assign w_abort = ((r_state == ST_WAIT_BUSY) && !xfer_busy && (r_wdog == 8'd7)) ||
                   ((r_state == ST_RUN)       &&  xfer_busy && (r_wdog == 8'd254));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wdog     <= 8'd0;
      r_wdog_err <= 1'b0;
    end else begin
      if (w_state_nxt != r_state) r_wdog <= 8'd0;
      else if ((r_state == ST_WAIT_BUSY) || (r_state == ST_RUN)) r_wdog <= r_wdog + 8'd1;
      if (w_abort) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_abort = 1'b0;
`endif

  assign pending = r_pending;
  assign err_pad = r_err_pad;
  assign wr_en   = r_wr_en;
  assign wr_pad  = r_wr_pad;
  assign wr_data = r_wr_data;

endmodule
`default_nettype wire
